muldiv_unit: RTL

Iterative RV32M multiply/divide execution unit. It sits between operand read and writeback. It consumes the two source-register read values for an M-extension instruction and produces the register-file write triple (we, address, data) that feeds the register file write port. It uses one shared 32-iteration datapath: shift-add for multiply, restoring division for divide/remainder.

---
 rtl/muldiv_unit.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, 32 iterations.
// Optional macro MULDIV_EARLY_OUT_EN lets trivial operands (A==0, B==0, signed overflow) bypass CALC.
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [RA_W-1:0] rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    output logic            wb_we,
    output logic [RA_W-1:0] wb_wa,
    output logic [XLEN-1:0] wb_wd
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_W = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_W  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]        state_r;
    logic [5:0]        cnt_r;
    logic [2:0]        op_r;
    logic [RA_W-1:0]   rd_r;
    logic              neg_r;
    logic              a_zero_r;
    logic              b_zero_r;
    logic              ovf_r;
    logic [XLEN-1:0]   a_mag_r;
    logic [XLEN-1:0]   b_mag_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   rem_r;

    logic              out_valid_r;
    logic              wb_we_r;
    logic [RA_W-1:0]   wb_wa_r;
    logic [XLEN-1:0]   wb_wd_r;

    logic              accept_s;
    logic              a_signed_s;
    logic              b_signed_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic              neg_s;
    logic              a_zero_s;
    logic              b_zero_s;
    logic              ovf_s;
    logic              early_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;

    logic [XLEN:0]     add_s;
    logic [2*XLEN-1:0] mul_next_s;
    logic [XLEN:0]     shl_s;
    logic [XLEN:0]     diff_s;
    logic [XLEN-1:0]   rem_next_s;
    logic [XLEN-1:0]   quo_next_s;
    logic [XLEN-1:0]   hi_neg_s;
    logic [XLEN-1:0]   res_s;

    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign accept_s  = in_valid && (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign wb_we     = wb_we_r;
    assign wb_wa     = wb_wa_r;
    assign wb_wd     = wb_wd_r;

    // Operand decode at accept: signedness, magnitudes, result sign and special cases.
    always_comb begin
        a_signed_s = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed_s = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg_s    = a_signed_s && rs1_data[XLEN-1];
        b_neg_s    = b_signed_s && rs2_data[XLEN-1];
        a_mag_s    = a_neg_s ? twos_neg(rs1_data) : rs1_data;
        b_mag_s    = b_neg_s ? twos_neg(rs2_data) : rs2_data;
        a_zero_s   = (rs1_data == ZERO_W);
        b_zero_s   = (rs2_data == ZERO_W);
        ovf_s      = ((op == OP_DIV) || (op == OP_REM)) && (rs1_data == MIN_W) && (rs2_data == ONES_W);
        case (op)
            OP_MULH, OP_DIV:  neg_s = a_neg_s ^ b_neg_s;
            OP_MULHSU, OP_REM: neg_s = a_neg_s;
            default:          neg_s = 1'b0;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign early_s = a_zero_s || b_zero_s || ovf_s;
`else
    assign early_s = 1'b0;
`endif

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        add_s      = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, a_mag_r} : {(XLEN+1){1'b0}});
        mul_next_s = {add_s, acc_r[XLEN-1:1]};
        shl_s      = {rem_r, acc_r[XLEN-1]};
        diff_s     = shl_s - {1'b0, b_mag_r};
        if (!diff_s[XLEN]) begin
            rem_next_s = diff_s[XLEN-1:0];
            quo_next_s = {acc_r[XLEN-2:0], 1'b1};
        end else begin
            rem_next_s = shl_s[XLEN-1:0];
            quo_next_s = {acc_r[XLEN-2:0], 1'b0};
        end
    end

    // Final result: sign fix-up, word select and forced special-case values.
    always_comb begin
        hi_neg_s = ~acc_r[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, (acc_r[XLEN-1:0] == ZERO_W)};
        res_s    = ZERO_W;
        case (op_r)
            OP_MUL: begin
                if (a_zero_r || b_zero_r) res_s = ZERO_W;
                else                      res_s = acc_r[XLEN-1:0];
            end
            OP_MULH, OP_MULHSU, OP_MULHU: begin
                if (a_zero_r || b_zero_r) res_s = ZERO_W;
                else if (neg_r)           res_s = hi_neg_s;
                else                      res_s = acc_r[2*XLEN-1:XLEN];
            end
            OP_DIV, OP_DIVU: begin
                if (b_zero_r)      res_s = ONES_W;
                else if (ovf_r)    res_s = MIN_W;
                else if (a_zero_r) res_s = ZERO_W;
                else if (neg_r)    res_s = twos_neg(acc_r[XLEN-1:0]);
                else               res_s = acc_r[XLEN-1:0];
            end
            OP_REM, OP_REMU: begin
                // Divide by zero returns A, rebuilt from its magnitude and sign.
                if (b_zero_r)      res_s = neg_r ? twos_neg(a_mag_r) : a_mag_r;
                else if (ovf_r)    res_s = ZERO_W;
                else if (a_zero_r) res_s = ZERO_W;
                else if (neg_r)    res_s = twos_neg(rem_r);
                else               res_s = rem_r;
            end
            default: res_s = ZERO_W;
        endcase
    end

    // Control FSM and registered writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 6'd0;
            out_valid_r <= 1'b0;
            wb_we_r     <= 1'b0;
            wb_wa_r     <= {RA_W{1'b0}};
            wb_wd_r     <= ZERO_W;
        end else begin
            out_valid_r <= 1'b0;
            wb_we_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 6'd0;
                    if (accept_s) state_r <= early_s ? ST_DONE : ST_CALC;
                    else          state_r <= ST_IDLE;
                end
                ST_CALC: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 6'd0;
                    end else if (cnt_r == 6'd31) begin
                        state_r <= ST_DONE;
                        cnt_r   <= 6'd0;
                    end else begin
                        cnt_r   <= cnt_r + 6'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 6'd0;
                    if (!flush) begin
                        out_valid_r <= 1'b1;
                        wb_we_r     <= (rd_r != {RA_W{1'b0}});
                        wb_wa_r     <= rd_r;
                        wb_wd_r     <= res_s;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 6'd0;
                end
            endcase
        end
    end

    // Operand capture at accept and per-cycle datapath iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= 3'd0;
            rd_r     <= {RA_W{1'b0}};
            neg_r    <= 1'b0;
            a_zero_r <= 1'b0;
            b_zero_r <= 1'b0;
            ovf_r    <= 1'b0;
            a_mag_r  <= ZERO_W;
            b_mag_r  <= ZERO_W;
            acc_r    <= {(2*XLEN){1'b0}};
            rem_r    <= ZERO_W;
        end else if (accept_s) begin
            op_r     <= op;
            rd_r     <= rd_addr;
            neg_r    <= neg_s;
            a_zero_r <= a_zero_s;
            b_zero_r <= b_zero_s;
            ovf_r    <= ovf_s;
            a_mag_r  <= a_mag_s;
            b_mag_r  <= b_mag_s;
            // Low half holds the multiplier for MUL* or the dividend for DIV*/REM*.
            acc_r    <= {ZERO_W, op[2] ? a_mag_s : b_mag_s};
            rem_r    <= ZERO_W;
        end else if (state_r == ST_CALC) begin
            if (op_r[2]) begin
                acc_r <= {acc_r[2*XLEN-1:XLEN], quo_next_s};
                rem_r <= rem_next_s;
            end else begin
                acc_r <= mul_next_s;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule
